// File: rtl/bcd_xs3_serial_converter.sv
// ---------------------------------------------------------------------------
// bcd_xs3_serial_converter
//
// Converts a packed multi-digit word between BCD and excess-3, one 4-bit
// digit per clock, least-significant digit first. The whole word is accepted
// through a valid/ready handshake. The converted word is held on the output
// until the sink accepts it. The direction is chosen per word by in_mode_i.
//
// Parameters
//   DIGITS : number of 4-bit digits per word (1..16)
//   CNT_W  : width of the digit index counter, 2**CNT_W >= DIGITS
//
// Ports
//   clk         : rising-edge clock
//   rst         : asynchronous active-high reset
//   in_valid_i  : source presents a word on in_data_i / in_mode_i
//   in_ready_o  : converter can accept a word this cycle (IDLE only)
//   in_data_i   : packed digits, digit 0 in bits [3:0]
//   in_mode_i   : 0 = BCD->XS3 (add 3), 1 = XS3->BCD (subtract 3)
//   out_valid_o : out_data_o holds a finished word
//   out_ready_i : sink accepts the finished word this cycle
//   out_data_o  : converted word, same packing as in_data_i (0 when not valid)
//   out_err_o   : some input digit was outside the legal code set
//   busy_o      : conversion in progress
//
// Optional feature
//   BCD_XS3_ERR_DETECT_EN : when defined, every digit is checked against the
//   legal code set of the captured mode and a sticky flag drives out_err_o.
//   When undefined, no checker is built and out_err_o is tied low.
// ---------------------------------------------------------------------------
module bcd_xs3_serial_converter #(
    parameter int DIGITS = 4,
    parameter int CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [4*DIGITS-1:0]   in_data_i,
    input  logic                  in_mode_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [4*DIGITS-1:0]   out_data_o,
    output logic                  out_err_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIGITS - 1);

    state_t               state_q,    state_d;
    logic [4*DIGITS-1:0]  shiftReg_q, shiftReg_d;
    logic [CNT_W-1:0]     digitIdx_q, digitIdx_d;
    logic                 mode_q,     mode_d;

    logic [3:0]           lowDigit;
    logic [3:0]           convDigit;
    logic [4*DIGITS-1:0]  shiftedWord;

    // The digit being worked on is always the bottom nibble; after DIGITS
    // rotations every converted digit is back in its original position.
    // Each digit wraps modulo 16 on its own, no carry crosses digits.
    assign lowDigit  = shiftReg_q[3:0];
    assign convDigit = mode_q ? (lowDigit - 4'd3) : (lowDigit + 4'd3);

    // Rotate the converted digit into the top nibble. A one-digit word has no
    // upper part to shift down, so it gets its own branch.
    generate
        if (DIGITS == 1) begin : g_oneDigit
            assign shiftedWord = convDigit;
        end else begin : g_multiDigit
            assign shiftedWord = {convDigit, shiftReg_q[4*DIGITS-1:4]};
        end
    endgenerate

    // State, data and index registers. Reset drops any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            digitIdx_q <= '0;
            mode_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            digitIdx_q <= digitIdx_d;
            mode_q     <= mode_d;
        end
    end

    // Next-state logic. IDLE captures a word and its mode, CONV converts
    // one digit per clock, HOLD waits for the sink. in_ready_o is high only
    // in IDLE, so the IDLE branch needs only in_valid_i to accept.
    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        digitIdx_d = digitIdx_q;
        mode_d     = mode_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    shiftReg_d = in_data_i;
                    mode_d     = in_mode_i;
                    digitIdx_d = '0;
                    state_d    = CONV;
                end
            end
            CONV: begin
                shiftReg_d = shiftedWord;
                digitIdx_d = digitIdx_q + CNT_W'(1);
                if (digitIdx_q == LAST_IDX) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs come straight from the registered state. They stay stable
    // through any length of backpressure in HOLD, and no partial word is
    // ever visible.
    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == HOLD);
    assign busy_o      = (state_q == CONV);
    assign out_data_o  = out_valid_o ? shiftReg_q : '0;

`ifdef BCD_XS3_ERR_DETECT_EN
    logic errAcc_q, errAcc_d;
    logic digitIllegal;

    // Legal input codes: BCD 0..9 when adding 3, XS3 3..12 when subtracting.
    // The flag is sticky for the whole word and is cleared on accept. The
    // data path is not affected by it.
    always_comb begin
        digitIllegal = mode_q ? ((lowDigit < 4'd3) || (lowDigit > 4'd12))
                              : (lowDigit > 4'd9);
        errAcc_d = errAcc_q;
        if ((state_q == IDLE) && in_valid_i) begin
            errAcc_d = 1'b0;
        end else if ((state_q == CONV) && digitIllegal) begin
            errAcc_d = 1'b1;
        end
    end

    // Sticky error register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errAcc_q <= 1'b0;
        end else begin
            errAcc_q <= errAcc_d;
        end
    end

    assign out_err_o = out_valid_o & errAcc_q;
`else
    assign out_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_xs3_serial_converter.sv
// ---------------------------------------------------------------------------
// tb_bcd_xs3_serial_converter
//
// Self-checking bench for bcd_xs3_serial_converter. It drives a four-digit
// instance and a one-digit instance. The stimulus tasks push the expected
// word into a queue. A monitor for each instance pops that entry and compares
// it whenever the instance hands a word to the sink. Inputs change 1 time
// unit after the rising edge. The monitors sample on the falling edge.
// ---------------------------------------------------------------------------
module tb_bcd_xs3_serial_converter;

    localparam int DIGITS  = 4;
    localparam int DIGITS1 = 1;

`ifdef BCD_XS3_ERR_DETECT_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    typedef struct packed {
        logic        err;
        logic [15:0] data;
    } expItem_t;

    typedef struct packed {
        logic       err;
        logic [3:0] data;
    } expItem1_t;

    logic        clk;
    logic        rst;

    logic        inValid,  inReady,  inMode,  outValid,  outReady,  outErr,  busy;
    logic [15:0] inData,   outData;

    logic        inValid1, inReady1, inMode1, outValid1, outReady1, outErr1, busy1;
    logic [3:0]  inData1,  outData1;

    expItem_t    expQ[$];
    expItem1_t   expQ1[$];

    int          checks = 0;
    int          fails  = 0;

    bcd_xs3_serial_converter #(.DIGITS(DIGITS), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (inValid),
        .in_ready_o  (inReady),
        .in_data_i   (inData),
        .in_mode_i   (inMode),
        .out_valid_o (outValid),
        .out_ready_i (outReady),
        .out_data_o  (outData),
        .out_err_o   (outErr),
        .busy_o      (busy)
    );

    bcd_xs3_serial_converter #(.DIGITS(DIGITS1), .CNT_W(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (inValid1),
        .in_ready_o  (inReady1),
        .in_data_i   (inData1),
        .in_mode_i   (inMode1),
        .out_valid_o (outValid1),
        .out_ready_i (outReady1),
        .out_data_o  (outData1),
        .out_err_o   (outErr1),
        .busy_o      (busy1)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stops a run that hangs.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor for the four-digit instance. A handshake happens on the coming
    // rising edge when both signals are high here.
    always @(negedge clk) begin
        if (!rst && outValid && outReady) begin
            if (expQ.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected word: got 0x%0h, expected no output", outData);
            end else begin
                automatic expItem_t e = expQ.pop_front();
                checkOutput("outData", 64'(outData), 64'(e.data));
                checkOutput("outErr",  64'(outErr),  64'(e.err));
            end
        end
    end

    // Monitor for the one-digit instance.
    always @(negedge clk) begin
        if (!rst && outValid1 && outReady1) begin
            if (expQ1.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected word (1 digit): got 0x%0h, expected no output", outData1);
            end else begin
                automatic expItem1_t e = expQ1.pop_front();
                checkOutput("outData1", 64'(outData1), 64'(e.data));
                checkOutput("outErr1",  64'(outErr1),  64'(e.err));
            end
        end
    end

    // Offers one word to the four-digit instance and queues the expected
    // result. Latency is counted in rising edges, including the accept edge.
    // After accept, the task flips in_mode and in_data to show that only the
    // accept edge samples them.
    task automatic applyStimulus(input logic [15:0] data, input logic mode,
                                 input logic [15:0] expData, input logic expErr);
        int n;
        n = 0;
        while (!inReady && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("inReady before send", 64'(inReady), 64'(1));
        inData  = data;
        inMode  = mode;
        inValid = 1'b1;
        expQ.push_back('{err: expErr, data: expData});
        @(posedge clk); #1;
        inValid = 1'b0;
        inMode  = ~mode;
        inData  = ~data;
        n = 1;
        while (!outValid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("latency", 64'(n), 64'(DIGITS + 1));
    endtask

    task automatic applyStimulus1(input logic [3:0] data, input logic mode,
                                  input logic [3:0] expData, input logic expErr);
        int n;
        n = 0;
        while (!inReady1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("inReady1 before send", 64'(inReady1), 64'(1));
        inData1  = data;
        inMode1  = mode;
        inValid1 = 1'b1;
        expQ1.push_back('{err: expErr, data: expData});
        @(posedge clk); #1;
        inValid1 = 1'b0;
        inMode1  = ~mode;
        inData1  = ~data;
        n = 1;
        while (!outValid1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("latency1", 64'(n), 64'(DIGITS1 + 1));
    endtask

    // Waits, with a bound, until the current word has left the output stage.
    task automatic waitDrained();
        int n;
        n = 0;
        while ((outValid || outValid1) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("output drained", 64'(outValid | outValid1), 64'(0));
    endtask

    // Main sequence.
    initial begin
        rst       = 1'b1;
        inValid   = 1'b0;  inData  = '0; inMode  = 1'b0; outReady  = 1'b1;
        inValid1  = 1'b0;  inData1 = '0; inMode1 = 1'b0; outReady1 = 1'b1;

        // State during reset.
        repeat (3) @(negedge clk);
        checkOutput("reset inReady",  64'(inReady),  64'(1));
        checkOutput("reset outValid", 64'(outValid), 64'(0));
        checkOutput("reset outData",  64'(outData),  64'(0));
        checkOutput("reset outErr",   64'(outErr),   64'(0));
        checkOutput("reset busy",     64'(busy),     64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic conversions in both directions, plus per-digit wrap.
        applyStimulus(16'h1234, 1'b0, 16'h4567, 1'b0);   waitDrained();
        applyStimulus(16'hC3A6, 1'b1, 16'h9073, 1'b0);   waitDrained();
        applyStimulus(16'h9A00, 1'b0, 16'hCD33, ERR_ON); waitDrained();
        applyStimulus(16'h0000, 1'b1, 16'hDDDD, ERR_ON); waitDrained();
        applyStimulus(16'hFFFF, 1'b0, 16'h2222, ERR_ON); waitDrained();
        applyStimulus(16'h5555, 1'b0, 16'h8888, 1'b0);   waitDrained();

        // Backpressure: the output is held and a second word waits.
        outReady = 1'b0;
        applyStimulus(16'h0505, 1'b0, 16'h3838, 1'b0);
        inData  = 16'h0001;
        inMode  = 1'b0;
        inValid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("held outData",  64'(outData),  64'(16'h3838));
            checkOutput("held outErr",   64'(outErr),   64'(0));
            checkOutput("held outValid", 64'(outValid), 64'(1));
            checkOutput("held inReady",  64'(inReady),  64'(0));
            checkOutput("held busy",     64'(busy),     64'(0));
        end
        @(posedge clk); #1;
        outReady = 1'b1;
        expQ.push_back('{err: 1'b0, data: 16'h3334});
        @(posedge clk); #1;
        checkOutput("release outValid", 64'(outValid), 64'(0));
        checkOutput("release inReady",  64'(inReady),  64'(1));
        @(posedge clk); #1;
        checkOutput("second word accepted", 64'(busy), 64'(1));
        inValid = 1'b0;
        begin
            int n;
            n = 0;
            while (!outValid && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            checkOutput("second word valid", 64'(outValid), 64'(1));
        end
        waitDrained();

        // Reset two cycles into CONV aborts the word at once.
        inData  = 16'h1111;
        inMode  = 1'b0;
        inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("abort outValid", 64'(outValid), 64'(0));
        checkOutput("abort outData",  64'(outData),  64'(0));
        checkOutput("abort busy",     64'(busy),     64'(0));
        checkOutput("abort inReady",  64'(inReady),  64'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(16'h4321, 1'b0, 16'h7654, 1'b0);   waitDrained();

        // One-digit instance.
        applyStimulus1(4'h9, 1'b0, 4'hC, 1'b0);          waitDrained();
        applyStimulus1(4'h2, 1'b1, 4'hF, ERR_ON);        waitDrained();
        applyStimulus1(4'hF, 1'b0, 4'h2, ERR_ON);        waitDrained();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", 64'(expQ.size() + expQ1.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/bcd_xs3_serial_converter.md
Name: bcd_xs3_serial_converter

Overview:
- Parametrised multi-digit converter between packed BCD and excess-3 codes.
- Accepts one DIGITS-wide word per transaction through a valid/ready handshake.
- Converts one 4-bit digit per clock, least-significant digit first, then holds the result until the sink accepts it.
- Sits between the keypad/BCD datapath and the excess-3 arithmetic units. It also provides the reverse path, excess-3 to BCD, selected per transaction.

Parameters:
- DIGITS, 4, number of 4-bit digits per word (legal range 1..16)
- CNT_W, 4, width of the digit index counter; must satisfy 2^CNT_W >= DIGITS

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  source has a word on in_data/in_mode
- in_ready  output  1  block can accept a word this cycle
- in_data  input  4*DIGITS  packed digits; digit 0 = bits [3:0]
- in_mode  input  1  0 = BCD->XS3 (add 3), 1 = XS3->BCD (subtract 3)
- out_valid  output  1  out_data holds a finished word
- out_ready  input  1  sink accepts the word this cycle
- out_data  output  4*DIGITS  converted word, same packing
- out_err  output  1  at least one input digit was outside the legal code set (see Optional Feature)
- busy  output  1  conversion in progress

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset (asynchronous, immediate): state=IDLE, in_ready=1, out_valid=0, out_data=0, out_err=0, busy=0, digit index=0, internal shift register=0.
- FSM states: IDLE, CONV, HOLD.
  - IDLE: in_ready=1. On in_valid&in_ready, capture in_data into the shift register and in_mode into a mode register, clear the error accumulator, set index=0, go to CONV.
  - CONV: in_ready=0, busy=1. Each cycle, convert the low digit d:
    - mode 0: d+4'd3, mod 16
    - mode 1: d-4'd3, mod 16
  - CONV shifting: rotate the result into the top digit and shift the register right by 4, then increment the index. When index==DIGITS-1, go to HOLD on that edge.
  - HOLD: out_valid=1, out_data=shift register (all digits now back in original order), busy=0, in_ready=0. On out_ready, out_valid drops next cycle and the state returns to IDLE.
- Latency: handshake edge to out_valid high = DIGITS+1 clocks. Throughput = one word per DIGITS+2 clocks minimum.
- Backpressure: out_data and out_err are held stable while out_valid=1 and out_ready=0, indefinitely.
- in_valid in CONV or HOLD is ignored, because in_ready=0. The source must hold its word.
- out_ready outside HOLD has no effect.
- DIGITS=1: CONV lasts exactly one cycle.
- Arithmetic is strictly 4-bit per digit, with no carry between digits. Wrap examples: 4'hF+3=4'h2, 4'h0-3=4'hD.
- Reset asserted mid-CONV or mid-HOLD aborts the word; no partial result is ever presented. First legal handshake is the cycle after rst deasserts.
- in_mode is sampled only at the accept edge; later changes are ignored.

Optional Feature:
- Macro: BCD_XS3_ERR_DETECT_EN.
- Defined:
  - During CONV, each digit is checked against the code set for the captured mode:
    - mode 0: legal = 0..9
    - mode 1: legal = 3..12
  - Any illegal digit sets a sticky accumulator.
  - out_err = accumulator, valid while out_valid=1 and 0 otherwise.
  - Conversion of illegal digits still wraps mod 16; data is not altered.
- Undefined: no checker logic is built, and out_err is tied to 0.

Test Plan:
- Reset, then DIGITS=4, mode 0, in_data=16'h1234 -> out_valid exactly 5 clocks after accept, out_data=16'h4567, out_err=0.
- Mode 1, in_data=16'hC3A6 -> out_data=16'h9073, out_err=0.
- Mode 0, in_data=16'h9A00 -> out_data=16'hCD33.
  - With BCD_XS3_ERR_DETECT_EN: out_err=1.
  - Without it: out_err=0.
- Hold out_ready=0 for 10 cycles after out_valid -> out_data/out_err stable, in_ready=0, and a second in_valid word is not accepted. Raise out_ready -> next cycle IDLE, and the second word is accepted.
- Assert rst 2 cycles into CONV -> out_valid, out_data and busy go 0 immediately. A new word after release converts correctly.
- Mode 1, in_data=16'h0000 -> out_data=16'hDDDD (wrap).
  - With BCD_XS3_ERR_DETECT_EN: out_err=1.
  - DIGITS=1 build, mode 0, in_data=4'h9 -> out_data=4'hC after 2 clocks.
